// File: rtl/fmul_pipe_if.sv
// Operand and result AXI-Stream channels of the floating-point multiplier.
// slave is the multiplier's view; master is the view of whatever feeds and drains it.
interface fmul_pipe_if #(
  parameter int W = 32
);
  logic         s_axis_a_tvalid;
  logic         s_axis_a_tready;
  logic [W-1:0] s_axis_a_tdata;
  logic         s_axis_b_tvalid;
  logic         s_axis_b_tready;
  logic [W-1:0] s_axis_b_tdata;
  logic         m_axis_result_tvalid;
  logic         m_axis_result_tready;
  logic [W-1:0] m_axis_result_tdata;
  logic [3:0]   m_axis_result_tuser;

  modport slave (
    input  s_axis_a_tvalid, s_axis_a_tdata,
    input  s_axis_b_tvalid, s_axis_b_tdata,
    input  m_axis_result_tready,
    output s_axis_a_tready, s_axis_b_tready,
    output m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser
  );

  modport master (
    output s_axis_a_tvalid, s_axis_a_tdata,
    output s_axis_b_tvalid, s_axis_b_tdata,
    output m_axis_result_tready,
    input  s_axis_a_tready, s_axis_b_tready,
    input  m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser
  );
endinterface

// File: rtl/fmul_pipe.sv
// Three-stage parametrised floating-point multiplier (flush-to-zero, RNE or truncate)
// with a single pipeline enable driven by result-side backpressure.
module fmul_pipe #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int ROUND_EN = 1,
  parameter int SAT_MODE = 0
) (
  input  logic         aclk,
  input  logic         aresetn,
  fmul_pipe_if.slave   io
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MW;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_OVF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_NAN  = 2'd1;
  localparam logic [1:0] K_INF  = 2'd2;
  localparam logic [1:0] K_ZERO = 2'd3;

  // Handshake: a transfer happens on any edge where valid and ready are both high.
  // Both operand readies equal the pipeline enable and never look at the tvalids;
  // a pair is taken only when both operands are valid, otherwise a bubble enters.
  logic en;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_user;

  assign en                      = !out_valid || io.m_axis_result_tready;
  assign io.s_axis_a_tready      = en;
  assign io.s_axis_b_tready      = en;
  assign io.m_axis_result_tvalid = out_valid;
  assign io.m_axis_result_tdata  = out_data;
  assign io.m_axis_result_tuser  = out_user;

  // Stage 1 combinational: unpack and classify
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic [1:0]         kind;
  logic signed [EW-1:0] e_sum;

  always_comb begin
    sa     = io.s_axis_a_tdata[W-1];
    sb     = io.s_axis_b_tdata[W-1];
    ea     = io.s_axis_a_tdata[W-2 -: EXP_W];
    eb     = io.s_axis_b_tdata[W-2 -: EXP_W];
    fa     = io.s_axis_a_tdata[MAN_W-1:0];
    fb     = io.s_axis_b_tdata[MAN_W-1:0];
    a_zero = ~|ea;
    b_zero = ~|eb;
    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && ~|fa;
    b_inf  = (&eb) && ~|fb;
    e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS;
    kind   = K_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) kind = K_NAN;
    else if (a_inf || b_inf)                                        kind = K_INF;
    else if (a_zero || b_zero)                                      kind = K_ZERO;
  end

  // Pipeline registers
  logic                 v1, v2, s1, s2;
  logic signed [EW-1:0] e1, e2;
  logic [MW-1:0]        ma1, mb1;
  logic [PW-1:0]        p2;
  logic [1:0]           k1, k2;

  // Stage 3 combinational: normalise, round, pack, exceptions
  logic [MAN_W-1:0]     frac;
  logic                 guard, sticky, inexact, round_up, carry;
  logic [MAN_W-1:0]     frac_r;
  logic signed [EW-1:0] e_n;
  logic [W-1:0]         res_data;
  logic [3:0]           res_user;

  always_comb begin
    if (p2[PW-1]) begin
      frac   = p2[PW-2 -: MAN_W];
      guard  = p2[PW-MAN_W-2];
      sticky = |p2[PW-MAN_W-3:0];
    end else begin
      frac   = p2[PW-3 -: MAN_W];
      guard  = p2[PW-MAN_W-3];
      sticky = |p2[PW-MAN_W-4:0];
    end
    inexact  = guard || sticky;
    round_up = (ROUND_EN != 0) && guard && (sticky || frac[0]);
    // A carry out of the fraction means 1.11..1 rounded up to 10.0: the fraction
    // wraps to zero and the exponent takes the extra increment.
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    e_n = e2 + {{(EW-1){1'b0}}, p2[PW-1]} + {{(EW-1){1'b0}}, carry};

    res_data = {s2, e_n[EXP_W-1:0], frac_r};
    res_user = {3'b000, inexact};
    case (k2)
      K_NAN: begin
        res_data = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        res_user = 4'b1000;
      end
      K_INF: begin
        res_data = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        res_user = 4'b0000;
      end
      K_ZERO: begin
        res_data = {s2, {(W-1){1'b0}}};
        res_user = 4'b0000;
      end
      default: begin
        if (e_n >= E_OVF) begin
          if (SAT_MODE != 0) res_data = {s2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          else               res_data = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_user = 4'b0101;
        end else if (e_n <= E_ZERO) begin
          res_data = {s2, {(W-1){1'b0}}};
          res_user = 4'b0011;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1 <= 1'b0; s1 <= 1'b0; e1 <= '0; ma1 <= '0; mb1 <= '0; k1 <= K_NORM;
      v2 <= 1'b0; s2 <= 1'b0; e2 <= '0; p2 <= '0; k2 <= K_NORM;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
    end else if (en) begin
      v1  <= io.s_axis_a_tvalid && io.s_axis_b_tvalid;
      s1  <= sa ^ sb;
      e1  <= e_sum;
      ma1 <= {1'b1, fa};
      mb1 <= {1'b1, fb};
      k1  <= kind;
      v2  <= v1;
      s2  <= s1;
      e2  <= e1;
      p2  <= {{MW{1'b0}}, ma1} * {{MW{1'b0}}, mb1};
      k2  <= k1;
      out_valid <= v2;
      out_data  <= res_data;
      out_user  <= res_user;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: single precision with RNE, a truncating/saturating variant,
// and a half-precision instance, all checked against hand-derived products.
module tb_fmul_pipe;
  logic aclk;
  logic aresetn;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_out = 0;

  logic [35:0] exp_q[$];
  logic [35:0] alt_q[$];
  logic [19:0] half_q[$];

  fmul_pipe_if #(.W(32)) ifm ();
  fmul_pipe_if #(.W(32)) ifa ();
  fmul_pipe_if #(.W(16)) ifh ();

  fmul_pipe u_main (.aclk(aclk), .aresetn(aresetn), .io(ifm));
  fmul_pipe #(.ROUND_EN(0), .SAT_MODE(1)) u_alt (.aclk(aclk), .aresetn(aresetn), .io(ifa));
  fmul_pipe #(.EXP_W(5), .MAN_W(10)) u_half (.aclk(aclk), .aresetn(aresetn), .io(ifh));

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // scoreboard for the main instance: in-order compare plus hold-while-stalled check
  logic        stall_prev = 1'b0;
  logic [35:0] stall_val  = '0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (ifm.m_axis_result_tvalid !== 1'b1 ||
            {ifm.m_axis_result_tuser, ifm.m_axis_result_tdata} !== stall_val) begin
          fails++;
          $display("FAIL stall_hold: got v=%b %h, expected v=1 %h", ifm.m_axis_result_tvalid,
                   {ifm.m_axis_result_tuser, ifm.m_axis_result_tdata}, stall_val);
        end
      end
      if (ifm.m_axis_result_tvalid === 1'b1 && ifm.m_axis_result_tready === 1'b1) begin
        logic [35:0] e;
        tests++;
        n_out++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %h, expected no output",
                   {ifm.m_axis_result_tuser, ifm.m_axis_result_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({ifm.m_axis_result_tuser, ifm.m_axis_result_tdata} !== e) begin
            fails++;
            $display("FAIL result: got tuser=%b tdata=%h, expected tuser=%b tdata=%h",
                     ifm.m_axis_result_tuser, ifm.m_axis_result_tdata, e[35:32], e[31:0]);
          end
        end
      end
      stall_prev = ifm.m_axis_result_tvalid && !ifm.m_axis_result_tready;
      stall_val  = {ifm.m_axis_result_tuser, ifm.m_axis_result_tdata};
    end
  end

  // driver tasks
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    ifm.s_axis_a_tvalid = 1'b0;
    ifm.s_axis_b_tvalid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that took the pair.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp);
    int n;
    ifm.s_axis_a_tvalid = 1'b1;
    ifm.s_axis_b_tvalid = 1'b1;
    ifm.s_axis_a_tdata  = a;
    ifm.s_axis_b_tdata  = b;
    n = 0;
    @(negedge aclk);
    while (ifm.s_axis_a_tready !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got tready=%b after %0d cycles, expected 1", ifm.s_axis_a_tready, n);
    end else begin
      exp_q.push_back(exp);
      acc_cyc = cyc + 1;
    end
    @(posedge aclk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    #3;
    tests++;
    if (ifm.m_axis_result_tvalid !== 1'b0 || ifm.m_axis_result_tdata !== 32'h0 ||
        ifm.m_axis_result_tuser !== 4'h0 || ifm.s_axis_a_tready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%h u=%b rdy=%b, expected v=0 d=0 u=0 rdy=1",
               ifm.m_axis_result_tvalid, ifm.m_axis_result_tdata, ifm.m_axis_result_tuser,
               ifm.s_axis_a_tready);
    end
    idle_cycles(2);
    aresetn = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    int n;
    send(32'h3FC00000, 32'h40000000, {4'h0, 32'h40400000});
    idle_inputs();
    n = 0;
    while (ifm.m_axis_result_tvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    // latency counted with the acceptance edge as the first of the three
    tests++;
    if (n >= 20 || (cyc - acc_cyc + 1) != 3) begin
      fails++;
      $display("FAIL latency: got %0d edges, expected 3", cyc - acc_cyc + 1);
    end
    idle_cycles(3);
    send(32'hC0000000, 32'h40400000, {4'h0, 32'hC0C00000});
    idle_inputs();
    idle_cycles(5);
  endtask

  task automatic test_rounding_and_specials();
    logic [31:0] va[11];
    logic [31:0] vb[11];
    logic [35:0] ve[11];
    va = '{32'h3F800001, 32'h3FFFFFFF, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000,
           32'h7FC00001, 32'hFF800000, 32'h00000001, 32'h80000000, 32'h3F800000};
    vb = '{32'h3F800001, 32'h3FFFFFFF, 32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h00000000,
           32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3F800000};
    ve = '{{4'h1, 32'h3F800002}, {4'h1, 32'h407FFFFE}, {4'h1, 32'h3FC00002},
           {4'h5, 32'h7F800000}, {4'h3, 32'h00000000}, {4'h8, 32'h7FC00000},
           {4'h8, 32'h7FC00000}, {4'h0, 32'hFF800000}, {4'h0, 32'h00000000},
           {4'h0, 32'h80000000}, {4'h0, 32'h3F800000}};
    for (int i = 0; i < 11; i++) send(va[i], vb[i], ve[i]);
    idle_inputs();
    idle_cycles(6);
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] x;
          x = 32'h40100000 + (i << 16) + $urandom_range(0, 255);
          if (i % 2 == 1) send(32'h40000000, x, {4'h0, x + 32'h00800000});
          else            send(32'h3F800000, x, {4'h0, x});
        end
        idle_inputs();
      end
      begin
        idle_cycles(3);
        ifm.m_axis_result_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          tests++;
          if (ifm.s_axis_a_tready !== !ifm.m_axis_result_tvalid ||
              ifm.s_axis_b_tready !== !ifm.m_axis_result_tvalid) begin
            fails++;
            $display("FAIL stall_ready: got a=%b b=%b, expected %b", ifm.s_axis_a_tready,
                     ifm.s_axis_b_tready, !ifm.m_axis_result_tvalid);
          end
        end
        @(posedge aclk);
        #1;
        ifm.m_axis_result_tready = 1'b1;
      end
    join
    idle_cycles(8);
    tests++;
    if (n_out - n0 != 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d results, expected 6", n_out - n0);
    end
  endtask

  task automatic test_partial_valid();
    int n0;
    n0 = n_out;
    ifm.s_axis_a_tvalid = 1'b1;
    ifm.s_axis_a_tdata  = 32'h40000000;
    ifm.s_axis_b_tvalid = 1'b0;
    idle_cycles(6);
    idle_inputs();
    idle_cycles(2);
    tests++;
    if (n_out != n0) begin
      fails++;
      $display("FAIL partial_valid: got %0d results, expected 0", n_out - n0);
    end
    send(32'h40400000, 32'h40400000, {4'h0, 32'h41100000});
    idle_inputs();
    idle_cycles(5);
  endtask

  task automatic test_reset_in_flight();
    int n0;
    n0 = n_out;
    ifm.m_axis_result_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h3F800000, 32'h40A00000 + (i << 12), {4'h0, 32'h40A00000 + (i << 12)});
    idle_inputs();
    idle_cycles(2);
    tests++;
    if (ifm.m_axis_result_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL inflight_valid: got v=%b, expected 1", ifm.m_axis_result_tvalid);
    end
    #1;
    aresetn = 1'b0;
    #1;
    tests++;
    if (ifm.m_axis_result_tvalid !== 1'b0 || ifm.m_axis_result_tdata !== 32'h0 ||
        ifm.m_axis_result_tuser !== 4'h0) begin
      fails++;
      $display("FAIL async_reset: got v=%b d=%h u=%b, expected all 0", ifm.m_axis_result_tvalid,
               ifm.m_axis_result_tdata, ifm.m_axis_result_tuser);
    end
    exp_q.delete();
    idle_cycles(2);
    aresetn = 1'b1;
    ifm.m_axis_result_tready = 1'b1;
    idle_cycles(10);
    tests++;
    if (n_out != n0) begin
      fails++;
      $display("FAIL stale_after_reset: got %0d results, expected 0", n_out - n0);
    end
  endtask

  task automatic test_alt_case(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp);
    int n;
    logic [35:0] e;
    @(posedge aclk);
    #1;
    ifa.s_axis_a_tvalid = 1'b1;
    ifa.s_axis_b_tvalid = 1'b1;
    ifa.s_axis_a_tdata  = a;
    ifa.s_axis_b_tdata  = b;
    @(negedge aclk);
    if (ifa.s_axis_a_tready === 1'b1) alt_q.push_back(exp);
    @(posedge aclk);
    #1;
    ifa.s_axis_a_tvalid = 1'b0;
    ifa.s_axis_b_tvalid = 1'b0;
    n = 0;
    while (ifa.m_axis_result_tvalid !== 1'b1 && n < 10) begin
      @(negedge aclk);
      n++;
    end
    tests++;
    if (n >= 10 || alt_q.size() == 0) begin
      fails++;
      $display("FAIL alt_timeout: got no result, expected %h", exp);
    end else begin
      e = alt_q.pop_front();
      if ({ifa.m_axis_result_tuser, ifa.m_axis_result_tdata} !== e) begin
        fails++;
        $display("FAIL alt_result: got %h, expected %h",
                 {ifa.m_axis_result_tuser, ifa.m_axis_result_tdata}, e);
      end
    end
  endtask

  task automatic test_half_case(input logic [15:0] a, input logic [15:0] b, input logic [19:0] exp);
    int n;
    logic [19:0] e;
    @(posedge aclk);
    #1;
    ifh.s_axis_a_tvalid = 1'b1;
    ifh.s_axis_b_tvalid = 1'b1;
    ifh.s_axis_a_tdata  = a;
    ifh.s_axis_b_tdata  = b;
    @(negedge aclk);
    if (ifh.s_axis_a_tready === 1'b1) half_q.push_back(exp);
    @(posedge aclk);
    #1;
    ifh.s_axis_a_tvalid = 1'b0;
    ifh.s_axis_b_tvalid = 1'b0;
    n = 0;
    while (ifh.m_axis_result_tvalid !== 1'b1 && n < 10) begin
      @(negedge aclk);
      n++;
    end
    tests++;
    if (n >= 10 || half_q.size() == 0) begin
      fails++;
      $display("FAIL half_timeout: got no result, expected %h", exp);
    end else begin
      e = half_q.pop_front();
      if ({ifh.m_axis_result_tuser, ifh.m_axis_result_tdata} !== e) begin
        fails++;
        $display("FAIL half_result: got %h, expected %h",
                 {ifh.m_axis_result_tuser, ifh.m_axis_result_tdata}, e);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    ifm.s_axis_a_tvalid = 1'b0; ifm.s_axis_b_tvalid = 1'b0;
    ifm.s_axis_a_tdata = '0; ifm.s_axis_b_tdata = '0; ifm.m_axis_result_tready = 1'b1;
    ifa.s_axis_a_tvalid = 1'b0; ifa.s_axis_b_tvalid = 1'b0;
    ifa.s_axis_a_tdata = '0; ifa.s_axis_b_tdata = '0; ifa.m_axis_result_tready = 1'b1;
    ifh.s_axis_a_tvalid = 1'b0; ifh.s_axis_b_tvalid = 1'b0;
    ifh.s_axis_a_tdata = '0; ifh.s_axis_b_tdata = '0; ifh.m_axis_result_tready = 1'b1;

    test_reset();
    test_basic();
    test_rounding_and_specials();
    test_back_to_back();
    test_partial_valid();
    test_reset_in_flight();
    test_basic();

    test_alt_case(32'h3F800001, 32'h3F800001, {4'h1, 32'h3F800002});
    test_alt_case(32'h3F800001, 32'h3FC00000, {4'h1, 32'h3FC00001});
    test_alt_case(32'h7F000000, 32'h40000000, {4'h5, 32'h7F7FFFFF});
    test_half_case(16'h3E00, 16'h4000, {4'h0, 16'h4200});
    test_half_case(16'h7800, 16'h4000, {4'h5, 16'h7C00});

    idle_cycles(5);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL lost_results: got %0d still pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised IEEE-754-style floating-point multiplier with a fixed 3-stage pipeline and full AXI-Stream valid/ready backpressure.
- Generalises the existing single-precision multiplier:
  - configurable exponent and mantissa widths;
  - round-to-nearest-even instead of truncation;
  - Inf/NaN handling and exception flags;
  - selectable overflow saturation.
- Sits in the SA datapath as the multiply stage feeding accumulators.

Parameters:
- EXP_W, 8: exponent field width. BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width. Data width W = 1+EXP_W+MAN_W.
- ROUND_EN, 1: 1 = round-to-nearest-even; 0 = truncate toward zero.
- SAT_MODE, 0: overflow result. 0 = signed infinity; 1 = signed max finite.

Ports:
- aclk  in  1  clock. Everything is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_a_tvalid  in  1  operand A valid.
- s_axis_a_tready  out  1  operand A ready.
- s_axis_a_tdata  in  W  operand A.
- s_axis_b_tvalid  in  1  operand B valid.
- s_axis_b_tready  out  1  operand B ready.
- s_axis_b_tdata  in  W  operand B.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream ready.
- m_axis_result_tdata  out  W  product.
- m_axis_result_tuser  out  4  flags: [0] inexact, [1] underflow, [2] overflow, [3] invalid.

Behaviour:
- Reset: while aresetn=0, all stage valids, m_axis_result_tvalid, tdata and tuser are 0. Deassertion is sampled on the next aclk edge.
- Pipeline enable: en = !m_axis_result_tvalid || m_axis_result_tready.
- Ready: s_axis_a_tready = s_axis_b_tready = en. Both readies are the same signal and do not depend on the tvalids.
- Accept: a pair is accepted on an edge where a_tvalid && b_tvalid && en.
  - If only one operand is valid, nothing is consumed and a bubble enters stage 1.
- Stall: when en=0 every stage holds, and tdata/tuser stay stable while tvalid=1 and tready=0.
- Ordering and capacity: results leave in acceptance order. No loss and no duplication. Maximum in flight: 3.
- Latency: an accepted pair appears on tvalid exactly 3 edges later, absent stalls. Throughput is 1 per cycle.
- Stage 1: unpack; classify each operand as zero (exp==0, subnormals flushed to zero), inf, NaN or normal; sign = sa^sb; signed exponent sum e = ea+eb-BIAS, held (EXP_W+2) bits wide.
- Stage 2: (MAN_W+1)x(MAN_W+1) product of the mantissas with hidden 1, 2*(MAN_W+1) bits wide.
- Stage 3: normalise, round and pack.
  - Normalise: if the product MSB is 1, shift right by 1 and increment e.
  - Round (ROUND_EN=1): guard bit plus sticky (OR of the lower bits); round up if guard && (sticky || lsb).
  - Rounding carry-out renormalises the mantissa to 1.0 and increments e.
  - Inexact = any discarded bit nonzero, regardless of ROUND_EN.
- Exceptions, in priority order:
  - NaN operand, or inf x zero: canonical qNaN {0, all-ones exp, 1, zeros}, invalid=1.
  - inf x (inf or normal): signed infinity, no flags.
  - Either operand zero: signed zero, no flags.
  - e >= 2^EXP_W-1: overflow=1, inexact=1. Result is signed inf if SAT_MODE=0, else signed max finite (exp all-ones minus 1, fraction all ones).
  - e <= 0: signed zero, underflow=1, inexact=1. No subnormal outputs.
- Reset mid-operation: all in-flight data is discarded immediately, and tvalid drops asynchronously.

Test Plan:
- Basic (EXP_W=8, MAN_W=23):
  - A=0x3FC00000, B=0x40000000 -> 0x40400000, tuser=0, tvalid exactly 3 edges after acceptance.
  - A=0xC0000000, B=0x40400000 -> 0xC0C00000.
- Rounding: A=B=0x3F800001 -> 0x3F800002, inexact=1. With ROUND_EN=0 -> 0x3F800002 as well. Also A=B=0x3FFFFFFF -> 0x407FFFFE with RNE, inexact=1.
- Overflow/underflow:
  - A=0x7F000000, B=0x40000000 -> 0x7F800000, tuser=0b0101. With SAT_MODE=1 -> 0x7F7FFFFF.
  - A=0x00800000, B=0x3F000000 -> 0x00000000, tuser=0b0011.
- Specials:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000, tuser=0b1000.
  - 0x7FC00001 x 0x3F800000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 x 0x40000000 -> 0xFF800000.
  - 0x00000001 x 0x40000000 -> 0x00000000, flags 0.
- Backpressure: stream 6 back-to-back pairs with tready low for 5 cycles from cycle 4 -> s_tready=0 during the stall, outputs stable, all 6 results in order, no duplicates. Also test A valid with B not valid -> nothing consumed.
- Reset and generics:
  - Assert aresetn low with 3 results in flight -> tvalid=0 immediately; after release, no stale results emerge.
  - Repeat the basic case with EXP_W=5, MAN_W=10 (half precision): 0x3E00 x 0x4000 -> 0x4200.
